// File: rtl/matrix_frame_buf.sv
// Double-buffered row store for an LED matrix. Rows fill a back buffer, and a complete frame
// is copied to the front buffer either on VSYNC or as soon as it is complete.
module matrix_frame_buf #(
  parameter int unsigned NUM_ROWS  = 8,
  parameter bit          SYNC_SWAP = 1'b1
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic [7:0]                  DIN,
  input  logic                        DVALID,
  output logic                        DREADY,
  input  logic                        SOF,
  input  logic                        VSYNC,
  output logic [8*NUM_ROWS-1:0]       FRAME,
  output logic                        SWAPPED,
  output logic [$clog2(NUM_ROWS)-1:0] WR_ROW,
  output logic [15:0]                 FRAME_CNT
);

  localparam int unsigned    RowW    = $clog2(NUM_ROWS);
  localparam logic [RowW-1:0] LastRow = RowW'(NUM_ROWS - 1);

  typedef enum logic {StFill, StPending} state_e;

  state_e                r_state;
  logic [RowW-1:0]       r_wr_row;
  logic [8*NUM_ROWS-1:0] r_back;
  logic [8*NUM_ROWS-1:0] r_front;
  logic                  r_swapped;
  logic [15:0]           r_frame_cnt;

  logic [RowW-1:0]       w_row;
  logic                  w_swap;

  // SOF restarts the fill; a byte arriving with it lands in row 0.
  always_comb begin
    w_row  = SOF ? '0 : r_wr_row;
    w_swap = (r_state == StPending) && (!SYNC_SWAP || VSYNC);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state     <= StFill;
      r_wr_row    <= '0;
      r_back      <= '0;
      r_front     <= '0;
      r_swapped   <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_swapped <= 1'b0;
      unique case (r_state)
        StFill: begin
          if (DVALID) begin
            r_back[{w_row, 3'b000} +: 8] <= DIN;
            if (w_row == LastRow) begin
              r_wr_row <= '0;
              r_state  <= StPending;
            end else begin
              r_wr_row <= w_row + RowW'(1);
            end
          end else begin
            r_wr_row <= w_row;
          end
        end
        StPending: begin
          if (w_swap) begin
            r_front     <= r_back;
            r_swapped   <= 1'b1;
            r_frame_cnt <= r_frame_cnt + 16'd1;
            r_state     <= StFill;
          end
        end
        default: r_state <= StFill;
      endcase
    end
  end

  assign DREADY    = (r_state == StFill);
  assign FRAME     = r_front;
  assign SWAPPED   = r_swapped;
  assign WR_ROW    = r_wr_row;
  assign FRAME_CNT = r_frame_cnt;

endmodule

// File: tb/tb_matrix_frame_buf.sv
// Directed bench for matrix_frame_buf: one VSYNC-swapped instance and one immediate-swap
// instance share the stimulus.
module tb_matrix_frame_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  din;
  logic        dvalid, sof, vsync;

  logic        dready, swapped;
  logic [63:0] frame;
  logic [2:0]  wr_row;
  logic [15:0] frame_cnt;

  logic        dready0, swapped0;
  logic [63:0] frame0;
  logic [2:0]  wr_row0;
  logic [15:0] frame_cnt0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  matrix_frame_buf #(.NUM_ROWS(8), .SYNC_SWAP(1'b1)) dut (
    .CLK(clk), .RESET(rst), .DIN(din), .DVALID(dvalid), .DREADY(dready), .SOF(sof),
    .VSYNC(vsync), .FRAME(frame), .SWAPPED(swapped), .WR_ROW(wr_row), .FRAME_CNT(frame_cnt)
  );

  matrix_frame_buf #(.NUM_ROWS(8), .SYNC_SWAP(1'b0)) dut0 (
    .CLK(clk), .RESET(rst), .DIN(din), .DVALID(dvalid), .DREADY(dready0), .SOF(sof),
    .VSYNC(vsync), .FRAME(frame0), .SWAPPED(swapped0), .WR_ROW(wr_row0),
    .FRAME_CNT(frame_cnt0)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    din    = b;
    dvalid = 1'b1;
    tick();
    dvalid = 1'b0;
  endtask

  task automatic pulse_vsync();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
  endtask

  // Called just after a rising edge; keeps reset edges clear of clock edges.
  task automatic do_reset();
    #2 rst = 1'b1;
    #10 rst = 1'b0;
    tick();
  endtask

  initial begin
    int sent;
    int cycles;
    int low_cnt;
    logic acc;

    rst = 1'b1; din = '0; dvalid = 1'b0; sof = 1'b0; vsync = 1'b0;
    #3;
    check_eq("rst_frame",   frame, 64'h0);
    check_eq("rst_wr_row",  64'(wr_row), 64'h0);
    check_eq("rst_cnt",     64'(frame_cnt), 64'h0);
    check_eq("rst_dready",  64'(dready), 64'h1);
    check_eq("rst_swapped", 64'(swapped), 64'h0);
    #9 rst = 1'b0;
    tick();
    check_eq("post_rst_dready", 64'(dready), 64'h1);

    // Basic fill and VSYNC swap
    for (int i = 0; i < 8; i++) write_byte(8'(i + 1));
    check_eq("t1_pending_dready", 64'(dready), 64'h0);
    check_eq("t1_wr_row_wrap",    64'(wr_row), 64'h0);
    check_eq("t1_frame_held",     frame, 64'h0);
    pulse_vsync();
    check_eq("t1_frame",   frame, 64'h0807060504030201);
    check_eq("t1_swapped", 64'(swapped), 64'h1);
    check_eq("t1_cnt",     64'(frame_cnt), 64'h1);
    check_eq("t1_dready",  64'(dready), 64'h1);
    tick();
    check_eq("t1_swapped_once", 64'(swapped), 64'h0);

    // VSYNC withheld with DVALID held high
    for (int i = 0; i < 8; i++) write_byte(8'(8'h10 + i));
    din = 8'hFF; dvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_eq("t2_hold_dready", 64'(dready), 64'h0);
      check_eq("t2_hold_frame",  frame, 64'h0807060504030201);
    end
    dvalid = 1'b0;
    pulse_vsync();
    check_eq("t2_frame",  frame, 64'h1716151413121110);
    check_eq("t2_dready", 64'(dready), 64'h1);
    check_eq("t2_cnt",    64'(frame_cnt), 64'h2);

    // SOF restart after a partial fill
    for (int i = 0; i < 3; i++) write_byte(8'hAA);
    check_eq("t3_wr_row_partial", 64'(wr_row), 64'h3);
    sof = 1'b1;
    write_byte(8'h11);
    sof = 1'b0;
    check_eq("t3_wr_row_sof", 64'(wr_row), 64'h1);
    for (int i = 0; i < 7; i++) write_byte(8'h22);
    pulse_vsync();
    check_eq("t3_frame",  frame, 64'h2222222222222211);
    check_eq("t3_wr_row", 64'(wr_row), 64'h0);
    check_eq("t3_cnt",    64'(frame_cnt), 64'h3);

    // VSYNC coincident with the last row does not swap
    for (int i = 0; i < 7; i++) write_byte(8'(8'h30 + i));
    vsync = 1'b1;
    write_byte(8'h37);
    vsync = 1'b0;
    check_eq("t4_no_swap",   64'(swapped), 64'h0);
    check_eq("t4_frame_old", frame, 64'h2222222222222211);
    check_eq("t4_dready",    64'(dready), 64'h0);
    tick();
    check_eq("t4_still_no_swap", 64'(swapped), 64'h0);
    pulse_vsync();
    check_eq("t4_frame",   frame, 64'h3736353433323130);
    check_eq("t4_swapped", 64'(swapped), 64'h1);
    check_eq("t4_cnt",     64'(frame_cnt), 64'h4);

    // Immediate-swap instance, 16 bytes streamed with handshake
    do_reset();
    sent = 0; cycles = 0; low_cnt = 0;
    while (sent < 16 && cycles < 100) begin
      din    = 8'(8'h40 + sent);
      dvalid = 1'b1;
      acc    = dready0;
      tick();
      cycles++;
      if (acc) sent++;
      else low_cnt++;
    end
    dvalid = 1'b0;
    check_eq("t5_all_sent",   64'(sent), 64'd16);
    check_eq("t5_low_cycles", 64'(low_cnt), 64'd1);
    check_eq("t5_pending",    64'(dready0), 64'h0);
    check_eq("t5_frame1",     frame0, 64'h4746454443424140);
    tick();
    check_eq("t5_swapped", 64'(swapped0), 64'h1);
    check_eq("t5_frame2",  frame0, 64'h4F4E4D4C4B4A4948);
    check_eq("t5_cnt",     64'(frame_cnt0), 64'h2);
    check_eq("t5_dready",  64'(dready0), 64'h1);

    // Asynchronous reset mid-fill
    do_reset();
    for (int i = 0; i < 8; i++) write_byte(8'(8'h50 + i));
    pulse_vsync();
    check_eq("t6_frame_pre", frame, 64'h5756555453525150);
    for (int i = 0; i < 5; i++) write_byte(8'h60);
    check_eq("t6_wr_row_pre", 64'(wr_row), 64'h5);
    #2 rst = 1'b1;
    #1;
    check_eq("t6_frame",  frame, 64'h0);
    check_eq("t6_wr_row", 64'(wr_row), 64'h0);
    check_eq("t6_cnt",    64'(frame_cnt), 64'h0);
    #9 rst = 1'b0;
    tick();
    check_eq("t6_dready", 64'(dready), 64'h1);
    vsync = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t6_no_swap",    64'(swapped), 64'h0);
      check_eq("t6_frame_zero", frame, 64'h0);
    end
    vsync = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_frame_buf.md
MATRIX_FRAME_BUF -- requirements
Module: matrix_frame_buf

Interface
REQ-001 SHALL have parameter NUM_ROWS, default 8, rows per frame (one byte per row).
REQ-002 SHALL have parameter SYNC_SWAP, default 1; 1 = swap on VSYNC, 0 = swap immediately when the frame is complete.
REQ-003 SHALL have port CLK  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port RESET  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port DIN  input  8  row byte from upstream source.
REQ-006 SHALL have port DVALID  input  1  DIN valid.
REQ-007 SHALL have port DREADY  output  1  block can accept DIN.
REQ-008 SHALL have port SOF  input  1  start-of-frame, restarts back-buffer fill at row 0.
REQ-009 SHALL have port VSYNC  input  1  one-cycle frame-boundary pulse from the downstream matrix scan driver.
REQ-010 SHALL have port FRAME  output  8*NUM_ROWS  front buffer, byte k at bits [8k+7:8k], fed to the matrix driver data input.
REQ-011 SHALL have port SWAPPED  output  1  one-cycle pulse on each front-buffer update.
REQ-012 SHALL have port WR_ROW  output  $clog2(NUM_ROWS)  next back-buffer row to be written.
REQ-013 SHALL have port FRAME_CNT  output  16  count of completed swaps.

Function
REQ-014 SHALL hold two registers: back buffer (write side) and front buffer (drives FRAME).
REQ-015 SHALL implement states FILL and PENDING.
REQ-016 In FILL, DREADY SHALL be 1; in PENDING, DREADY SHALL be 0.
REQ-017 A byte SHALL be accepted only on a clock edge where DVALID=1 and DREADY=1; DIN is written to back-buffer row WR_ROW and WR_ROW increments.
REQ-018 Accepting the byte at WR_ROW=NUM_ROWS-1 SHALL set WR_ROW to 0 and move FILL->PENDING.
REQ-019 SOF=1 in FILL SHALL set WR_ROW to 0; if DVALID=1 in the same cycle, that byte SHALL be written to row 0 and WR_ROW SHALL become 1.
REQ-020 SOF SHALL be ignored in PENDING; VSYNC SHALL be ignored in FILL.
REQ-021 SYNC_SWAP=1: in PENDING, VSYNC=1 SHALL copy back->front, pulse SWAPPED, increment FRAME_CNT, and move to FILL, all on the same edge.
REQ-022 SYNC_SWAP=0: the swap of REQ-021 SHALL occur on the first edge after entering PENDING, regardless of VSYNC.
REQ-023 VSYNC coincident with acceptance of the last row SHALL NOT swap; the swap waits for the next VSYNC while in PENDING.
REQ-024 FRAME SHALL change only on swap edges; it is stable between swaps, so the driver never sees a partial frame.
REQ-025 FRAME_CNT SHALL wrap from 16'hFFFF to 0.
REQ-026 Back-buffer rows not rewritten since the last swap SHALL keep their previous contents.
REQ-027 Latency: the last byte is accepted at edge N; with SYNC_SWAP=0, FRAME updates at edge N+1; with SYNC_SWAP=1, at the first VSYNC edge after N.

Reset
REQ-028 While RESET=1 (asynchronously): state FILL, WR_ROW=0, back and front buffers all zero, FRAME=0, SWAPPED=0, FRAME_CNT=0, DREADY=1.
REQ-029 Reset mid-fill or in PENDING SHALL discard the partial or pending frame; no swap SHALL occur.
REQ-030 After RESET deasserts, DREADY SHALL be 1 on the first edge.

Verification
REQ-031 SYNC_SWAP=1, write bytes 0x01..0x08, then pulse VSYNC -> FRAME=64'h0807060504030201 one edge after VSYNC, SWAPPED pulses once, FRAME_CNT=1.
REQ-032 Full frame written, VSYNC withheld 20 cycles, DVALID held 1 -> DREADY=0 throughout, FRAME unchanged; first VSYNC then swaps and DREADY returns to 1.
REQ-033 Write 3 bytes 0xAA, then SOF with DIN=0x11, then 7 bytes 0x22, then VSYNC -> row0=0x11, rows1..7=0x22, WR_ROW=0 after the swap.
REQ-034 VSYNC on the same edge as the 8th byte -> no swap; the next VSYNC swaps; FRAME_CNT increments by exactly 1.
REQ-035 SYNC_SWAP=0, back-to-back 16 bytes with DVALID=1 -> two swaps, DREADY low for exactly one cycle after each 8th byte.
REQ-036 RESET asserted asynchronously after 5 bytes -> FRAME=0, WR_ROW=0, FRAME_CNT=0 immediately; no SWAPPED pulse follows.
